// File: rtl/store_unit_pkg.sv
// store_unit_pkg: shared definitions for the CPU write path.
//   - mode_e  : write transaction kinds (single store, 1..3 byte pushes)
//   - state_e : store_unit FSM states
//   - default widths, stack page and stack pointer reset value
//   - byte_count(): number of bus bytes a transaction writes
package store_unit_pkg;

    localparam int unsigned   ADDR_WIDTH_DEFAULT = 16;
    localparam int unsigned   REG_WIDTH_DEFAULT  = 8;
    localparam logic [7:0]    STACK_PAGE_DEFAULT = 8'h01;
    localparam logic [7:0]    SP_RESET_DEFAULT   = 8'hFD;

    typedef enum logic [1:0] {
        STORE_ABS = 2'b00,
        PUSH1     = 2'b01,
        PUSH2     = 2'b10,
        PUSH3     = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    // Bytes written on the bus for a given transaction kind.
    function automatic logic [1:0] byte_count(input mode_e m);
        logic [1:0] k;
        case (m)
            STORE_ABS: k = 2'd1;
            PUSH1:     k = 2'd1;
            PUSH2:     k = 2'd2;
            PUSH3:     k = 2'd3;
            default:   k = 2'd1;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// store_unit_if: request, stack-pointer and memory-write signals of the
// store unit.
//   master : execute/control side (drives req/mode/addr_in/data*/sp_load)
//   slave  : store_unit (drives mem_addr/mem_data_out/mem_we/busy/
//            write_done/sp_out)
interface store_unit_if
    import store_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned REG_WIDTH  = REG_WIDTH_DEFAULT
);
    logic                  req;
    logic [1:0]            mode;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [REG_WIDTH-1:0]  data0;
    logic [REG_WIDTH-1:0]  data1;
    logic [REG_WIDTH-1:0]  data2;
    logic                  sp_load;
    logic [REG_WIDTH-1:0]  sp_wr_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_data_out;
    logic                  mem_we;
    logic                  busy;
    logic                  write_done;
    logic [REG_WIDTH-1:0]  sp_out;

    modport master (
        output req, mode, addr_in, data0, data1, data2, sp_load, sp_wr_data,
        input  mem_addr, mem_data_out, mem_we, busy, write_done, sp_out
    );

    modport slave (
        input  req, mode, addr_in, data0, data1, data2, sp_load, sp_wr_data,
        output mem_addr, mem_data_out, mem_we, busy, write_done, sp_out
    );
endinterface

// File: rtl/store_unit_stack_pointer.sv
// stack_pointer: stack pointer register with load and post-decrement.
//   clk, reset_n (synchronous, active-low) -> sp = RESET_VAL
//   load/load_val : replace sp
//   dec           : decrement by one (wraps 0 -> all ones); when both are
//                   set the decrement applies to the loaded value
//   sp            : current value
module stack_pointer #(
    parameter int unsigned         WIDTH     = 8,
    parameter logic [WIDTH-1:0]    RESET_VAL = 8'hFD
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] sp
);
    logic [WIDTH-1:0] sp_r;
    logic [WIDTH-1:0] sp_base_s;
    logic [WIDTH-1:0] dec_ext_s;

    // Select the value the decrement works from (load wins over current sp).
    always_comb begin
        sp_base_s = sp_r;
        dec_ext_s = {{(WIDTH-1){1'b0}}, dec};
        if (load) begin
            sp_base_s = load_val;
        end else begin
            sp_base_s = sp_r;
        end
    end

    // Stack pointer register; modular subtraction gives the page wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sp_r <= RESET_VAL;
        end else if (load || dec) begin
            sp_r <= sp_base_s - dec_ext_s;
        end
    end

    assign sp = sp_r;
endmodule

// File: rtl/store_unit.sv
// store_unit: performs all CPU-initiated memory writes.
//   phi1    : clock, all state on posedge
//   reset_n : synchronous, active-low; aborts any transaction in flight
//   bus     : store_unit_if.slave
//     req/mode/addr_in/data0..2 : transaction request, latched in IDLE
//     sp_load/sp_wr_data        : stack pointer load, honoured in IDLE only
//     mem_addr/mem_data_out/mem_we : registered write port, one byte/cycle
//     busy, write_done          : status; write_done pulses after last byte
//     sp_out                    : live stack pointer
module store_unit
    import store_unit_pkg::*;
#(
    parameter int unsigned                          ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned                          REG_WIDTH  = REG_WIDTH_DEFAULT,
    parameter logic [ADDR_WIDTH-REG_WIDTH-1:0]      STACK_PAGE = STACK_PAGE_DEFAULT,
    parameter logic [REG_WIDTH-1:0]                 SP_RESET   = SP_RESET_DEFAULT
) (
    input  logic         phi1,
    input  logic         reset_n,
    store_unit_if.slave  bus
);
    state_e                state_r, state_nxt_s;
    mode_e                 mode_r;
    logic [REG_WIDTH-1:0]  data1_r, data2_r;
    logic [1:0]            cnt_r, cnt_nxt_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [REG_WIDTH-1:0]  mem_data_r, mem_data_nxt_s;
    logic                  mem_we_r, mem_we_nxt_s;
    logic                  busy_r, busy_nxt_s;
    logic                  done_r, done_nxt_s;
    logic                  latch_s;
    logic                  sp_ld_s;
    logic                  sp_dec_s;
    logic [REG_WIDTH-1:0]  sp_s;
    logic [REG_WIDTH-1:0]  sp_start_s;

    stack_pointer #(
        .WIDTH     (REG_WIDTH),
        .RESET_VAL (SP_RESET)
    ) u_sp (
        .clk      (phi1),
        .reset_n  (reset_n),
        .load     (sp_ld_s),
        .load_val (bus.sp_wr_data),
        .dec      (sp_dec_s),
        .sp       (sp_s)
    );

    // A push accepted together with sp_load starts from the loaded value.
    always_comb begin
        if (bus.sp_load) begin
            sp_start_s = bus.sp_wr_data;
        end else begin
            sp_start_s = sp_s;
        end
    end

    // Next-state and next-output logic of the write FSM.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        mem_addr_nxt_s = mem_addr_r;
        mem_data_nxt_s = mem_data_r;
        mem_we_nxt_s   = 1'b0;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        latch_s        = 1'b0;
        sp_ld_s        = 1'b0;
        sp_dec_s       = 1'b0;
        case (state_r)
            IDLE: begin
                sp_ld_s = bus.sp_load;
                if (bus.req) begin
                    latch_s        = 1'b1;
                    state_nxt_s    = WRITE;
                    cnt_nxt_s      = 2'd0;
                    mem_we_nxt_s   = 1'b1;
                    busy_nxt_s     = 1'b1;
                    mem_data_nxt_s = bus.data0;
                    if (mode_e'(bus.mode) == STORE_ABS) begin
                        mem_addr_nxt_s = bus.addr_in;
                    end else begin
                        mem_addr_nxt_s = {STACK_PAGE, sp_start_s};
                        sp_dec_s       = 1'b1;
                    end
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            WRITE: begin
                // Only pushes have more than one byte, so later bytes
                // always target the stack page.
                if ((cnt_r + 2'd1) < byte_count(mode_r)) begin
                    cnt_nxt_s      = cnt_r + 2'd1;
                    mem_we_nxt_s   = 1'b1;
                    busy_nxt_s     = 1'b1;
                    mem_addr_nxt_s = {STACK_PAGE, sp_s};
                    mem_data_nxt_s = (cnt_r == 2'd0) ? data1_r : data2_r;
                    sp_dec_s       = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 2'd0;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 2'd0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, latched request and registered bus outputs.
    always_ff @(posedge phi1) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            cnt_r      <= 2'd0;
            mode_r     <= STORE_ABS;
            data1_r    <= {REG_WIDTH{1'b0}};
            data2_r    <= {REG_WIDTH{1'b0}};
            mem_addr_r <= {ADDR_WIDTH{1'b0}};
            mem_data_r <= {REG_WIDTH{1'b0}};
            mem_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            mem_addr_r <= mem_addr_nxt_s;
            mem_data_r <= mem_data_nxt_s;
            mem_we_r   <= mem_we_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            if (latch_s) begin
                mode_r  <= mode_e'(bus.mode);
                data1_r <= bus.data1;
                data2_r <= bus.data2;
            end
        end
    end

    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_data_out = mem_data_r;
    assign bus.mem_we       = mem_we_r;
    assign bus.busy         = busy_r;
    assign bus.write_done   = done_r;
    assign bus.sp_out       = sp_s;
endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side counterpart to the instruction fetcher: the fetcher reads operands and resolves effective addresses; this block performs all CPU-initiated memory writes.
- Covers single-byte stores (STA/STX/STY to a resolved address) and 1–3 byte stack pushes (PHA/PHP, JSR PCH/PCL, BRK/IRQ PCH/PCL/P).
- Owns the stack pointer register.
- Sits between the execute/control logic and the memory bus mux.

Parameters:
- ADDR_WIDTH, 16, memory address width
- REG_WIDTH, 8, data/register width
- STACK_PAGE, 8'h01, high byte of stack addresses
- SP_RESET, 8'hFD, stack pointer value after reset

Ports:
- phi1  in  1  clock; all state updates on posedge phi1
- reset_n  in  1  reset: synchronous, active-low
- req  in  1  start a write transaction; sampled only in IDLE
- mode  in  2  STORE_ABS / PUSH1 / PUSH2 / PUSH3
- addr_in  in  ADDR_WIDTH  target address for STORE_ABS; ignored for pushes
- data0  in  REG_WIDTH  first byte written (stored byte / PCH / pushed reg)
- data1  in  REG_WIDTH  second byte (PCL); used by PUSH2/PUSH3 only
- data2  in  REG_WIDTH  third byte (P); used by PUSH3 only
- sp_load  in  1  load SP from sp_wr_data (TXS)
- sp_wr_data  in  REG_WIDTH  new SP value
- mem_addr  out  ADDR_WIDTH  write address, registered
- mem_data_out  out  REG_WIDTH  write data, registered
- mem_we  out  1  write strobe, registered
- busy  out  1  high while a transaction is in progress
- write_done  out  1  one-cycle pulse after the last byte is written
- sp_out  out  REG_WIDTH  current stack pointer

Behaviour:
- Reset (reset_n=0 at posedge phi1):
  - state=IDLE, sp=SP_RESET.
  - mem_addr=0, mem_data_out=0, mem_we=0, busy=0, write_done=0, byte counter=0.
  - Reset mid-transaction aborts it: mem_we=0 after that edge, no write_done, remaining bytes discarded, sp=SP_RESET.
- States:
  - IDLE: if req, latch mode/addr_in/data0..2; drive byte 0 (mem_we=1, busy=1); go to WRITE.
  - WRITE: advance one byte per cycle. After the final byte's cycle, go to IDLE with mem_we=0, busy=0, write_done=1.
  - write_done is forced to 0 on every other edge.
- Byte count k: STORE_ABS=1, PUSH1=1, PUSH2=2, PUSH3=3.
- Latency: req sampled at edge N. Byte i is on the bus (mem_we=1) during the cycle after edge N+i, for i = 0..k-1. At edge N+k: mem_we=0, busy=0, write_done=1.
- Throughput: the next req can be accepted at edge N+k+1. Minimum spacing is k+1 cycles.
- STORE_ABS: mem_addr=addr_in (latched), mem_data_out=data0. sp is unchanged.
- PUSH:
  - Byte i goes to mem_addr = {STACK_PAGE, sp}, mem_data_out = data_i.
  - sp decrements by 1 at the same edge that drives each byte (post-decrement semantics, matching the 6502).
  - Wrap: sp 8'h00 decrements to 8'hFF; the address stays in page STACK_PAGE.
  - sp_out tracks each decrement live.
- Inputs are latched at acceptance. Changes to addr_in/data*/mode during WRITE have no effect.
- req while busy is ignored: no queueing, no error flag.
- sp_load in IDLE: sp = sp_wr_data at that edge.
- sp_load together with req in IDLE: load applies first; the push uses sp_wr_data as its starting SP.
- sp_load while busy is ignored.
- mode encodings outside the defined set do not exist (2-bit fully decoded).

Decomposition:
- Shared package/defines file:
  - mode codes: STORE_ABS=2'b00, PUSH1=2'b01, PUSH2=2'b10, PUSH3=2'b11
  - state encodings: IDLE, WRITE
  - STACK_PAGE and SP_RESET defaults, alongside the existing SELECTOR_*/AM3_* defines
- Natural sub-module: stack_pointer, an 8-bit register with load/decrement, wrap and reset value, reused later by the pull/RTS path.
- Everything else stays in store_unit.

Test Plan:
- Reset: hold reset_n=0 two cycles -> sp_out=8'hFD, mem_we=0, busy=0, write_done=0.
- STORE_ABS: addr_in=16'h0203, data0=8'h5A, req one cycle -> next cycle mem_we=1, mem_addr=16'h0203, mem_data_out=8'h5A. Following cycle mem_we=0, write_done=1. sp_out stays 8'hFD.
- PUSH2 (JSR) from sp=8'hFD: data0=8'h12, data1=8'h34 -> writes 8'h12@16'h01FD then 8'h34@16'h01FC. sp_out ends 8'hFB. write_done pulses exactly once, 3 cycles after req.
- Wrap: sp_load with 8'h01, then PUSH3 with data 8'hAA/8'hBB/8'hCC -> writes @16'h0101, 16'h0100, 16'h01FF. sp_out ends 8'hFE.
- Busy ignore: req for a second PUSH1 asserted during a PUSH3 -> only 3 writes occur; sp decrements by 3, not 4. Same test with sp_load while busy -> sp unaffected.
- Reset mid-PUSH3 after byte 1 -> no further mem_we, no write_done, sp_out=8'hFD; a fresh STORE_ABS afterwards completes normally.
